// File: rtl/ex_muldiv_if.sv
// Handshake and data bundle between the ID/EX stage and the iterative multiply/divide unit.
// Signal names follow the pipeline's existing port names.
interface ex_muldiv_if;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] RSdata_i;
  logic [31:0] RTdata_i;
  logic [4:0]  RDaddr_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  RDaddr_o;

  modport master (
    output start_i, op_i, RSdata_i, RTdata_i, RDaddr_i,
    input  stall_o, done_o, result_o, RDaddr_o
  );

  modport slave (
    input  start_i, op_i, RSdata_i, RTdata_i, RDaddr_i,
    output stall_o, done_o, result_o, RDaddr_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative 32-cycle unsigned multiply (shift-add) and divide (restoring) unit for the EX stage.
// Holds the pipeline via stall_o and pulses done_o with a registered result.
module ex_muldiv (
  input logic         clk_i,
  input logic         rst_i,
  ex_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  rd_q;
  logic [63:0] acc_q;
  logic [32:0] rem_q;
  logic        done_q;
  logic [31:0] result_q;
  logic [4:0]  rd_out_q;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [33:0] div_shift;
  logic [33:0] div_diff;
  logic        div_ge;
  logic [32:0] rem_next;
  logic [31:0] quo_next;
  logic [63:0] acc_next;
  logic [31:0] result_fin;

  // One iteration of both algorithms; op_q selects which one is kept.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = {rem_q, acc_q[31]};
    div_diff  = div_shift - {2'b00, b_q};
    div_ge    = ~div_diff[33];
    rem_next  = div_ge ? div_diff[32:0] : div_shift[32:0];
    quo_next  = {acc_q[30:0], div_ge};
    acc_next  = op_q[1] ? {acc_q[63:32], quo_next} : mul_next;
  end

  always_comb begin
    result_fin = '0;
    unique case (op_q)
      2'b00: result_fin = mul_next[31:0];
      2'b01: result_fin = mul_next[63:32];
      2'b10: result_fin = quo_next;
      2'b11: result_fin = rem_next[31:0];
      default: result_fin = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start_i) begin
            op_q    <= bus.op_i;
            a_q     <= bus.RSdata_i;
            b_q     <= bus.RTdata_i;
            rd_q    <= bus.RDaddr_i;
            // Multiply shifts the multiplier out of the low half; divide shifts the dividend.
            acc_q   <= {32'd0, (bus.op_i[1] ? bus.RSdata_i : bus.RTdata_i)};
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q <= acc_next;
          rem_q <= rem_next;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            result_q <= result_fin;
            rd_out_q <= rd_q;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.stall_o  = ((state_q == StIdle) && bus.start_i) || (state_q == StRun);
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.RDaddr_o = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: a timeline model predicts stall/done/result every cycle, while directed
// operations pin results and latencies to hand-computed literals.
module tb_ex_muldiv;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  ex_muldiv_if bus ();

  ex_muldiv dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] golden(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Model: an accepted op occupies cycles t0..t0+33, stalling through t0+32, done at t0+33.
  bit          armed = 1'b0;
  bit          busy  = 1'b0;
  int          t0    = 0;
  logic [31:0] pend_res = '0, last_res = '0;
  logic [4:0]  pend_rd  = '0, last_rd  = '0;

  always @(negedge clk) begin
    if (armed) begin
      if (busy && cyc == t0 + 33) begin
        last_res = pend_res;
        last_rd  = pend_rd;
      end
      chk("stall", {31'd0, bus.stall_o}, {31'd0, busy ? (cyc <= t0 + 32) : bus.start_i});
      chk("done", {31'd0, bus.done_o}, {31'd0, busy && (cyc == t0 + 33)});
      chk("result", bus.result_o, last_res);
      chk("rdaddr", {27'd0, bus.RDaddr_o}, {27'd0, last_rd});
    end
    if (rst) begin
      busy     = 1'b0;
      last_res = '0;
      last_rd  = '0;
      armed    = 1'b1;
    end else if (busy) begin
      if (cyc == t0 + 33) busy = 1'b0;
    end else if (bus.start_i) begin
      busy     = 1'b1;
      t0       = cyc;
      pend_res = golden(bus.op_i, bus.RSdata_i, bus.RTdata_i);
      pend_rd  = bus.RDaddr_i;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single cycle, then scramble operands while it runs.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int t);
    bus.start_i  = 1'b1;
    bus.op_i     = op;
    bus.RSdata_i = a;
    bus.RTdata_i = b;
    bus.RDaddr_i = rd;
    t = cyc;
    tick();
    bus.start_i  = 1'b0;
    bus.op_i     = ~op;
    bus.RSdata_i = $urandom;
    bus.RTdata_i = $urandom;
    bus.RDaddr_i = 5'(~rd);
  endtask

  task automatic wait_done(input int t, output logic [31:0] res, output logic [4:0] rd);
    bit found = 1'b0;
    res = 'x;
    rd  = 'x;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (bus.done_o) begin
        found = 1'b1;
        res   = bus.result_o;
        rd    = bus.RDaddr_o;
        chk("latency", cyc - t, 33);
      end
    end
    chk("done_seen", {31'd0, found}, 32'd1);
    tick();
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] lit);
    int          t;
    logic [31:0] res;
    logic [4:0]  rdo;
    issue(op, a, b, rd, t);
    wait_done(t, res, rdo);
    chk(name, res, lit);
    chk({name, "_rd"}, {27'd0, rdo}, {27'd0, rd});
  endtask

  initial begin
    int          t;
    int          ndone;
    int          dcyc;
    logic [31:0] res;
    logic [4:0]  rdo;

    rst          = 1'b1;
    bus.start_i  = 1'b0;
    bus.op_i     = '0;
    bus.RSdata_i = '0;
    bus.RTdata_i = '0;
    bus.RDaddr_i = '0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("reset_result", bus.result_o, 32'd0);
    tick();

    run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 5'd5, 32'd42);
    run_op("mul_ffff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001);
    run_op("mulhu_ffff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 5'd3, 32'd14);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd4, 32'd2);
    run_op("divu_msb_1", 2'b10, 32'h8000_0000, 32'd1, 5'd6, 32'h8000_0000);
    run_op("divu_by0", 2'b10, 32'h0000_1234, 32'd0, 5'd7, 32'hFFFF_FFFF);
    run_op("remu_by0", 2'b11, 32'h0000_1234, 32'd0, 5'd8, 32'h0000_1234);

    // Reset in cycle T+10 of a multiply.
    issue(2'b00, 32'd1000, 32'd1000, 5'd9, t);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("midrst_done", {31'd0, bus.done_o}, 32'd0);
    chk("midrst_result", bus.result_o, 32'd0);
    chk("midrst_rd", {27'd0, bus.RDaddr_o}, 32'd0);
    tick();
    repeat (40) tick();
    run_op("divu_9_3", 2'b10, 32'd9, 32'd3, 5'd10, 32'd3);

    // start held high across a whole operation: one pulse, re-accept only at T+34.
    bus.start_i  = 1'b1;
    bus.op_i     = 2'b01;
    bus.RSdata_i = 32'h0001_0000;
    bus.RTdata_i = 32'h0003_0000;
    bus.RDaddr_i = 5'd11;
    t     = cyc;
    ndone = 0;
    dcyc  = 0;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      if (bus.done_o) begin
        ndone++;
        dcyc = cyc;
      end
      tick();
    end
    @(negedge clk);
    chk("held_pulses", ndone, 1);
    chk("held_latency", dcyc - t, 33);
    chk("held_result", bus.result_o, 32'd3);
    chk("held_restart", {31'd0, bus.stall_o}, 32'd1);
    tick();
    bus.start_i = 1'b0;
    wait_done(t + 34, res, rdo);
    chk("held_second", res, 32'd3);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
